// File: rtl/clkdiv_pkg.sv
// Shared constants, types and helpers for the pixel clock divider.
// Dynamic ratio support is controlled by the CLKDIV_DYNAMIC_EN macro.
package clkdiv_pkg;

  localparam int DIV_W_DEF = 8;
  localparam int MIN_DIV   = 2;

  typedef enum logic {
    R_IDLE,
    R_PENDING
  } ratio_st_e;

  function automatic int unsigned half_up(
    input int unsigned n
  );
    return (n + 1) >> 1;
  endfunction

endpackage

// File: rtl/pixel_clock_gen_if.sv
// Output/ratio bundle of the pixel clock divider.
// Ratio-load signals exist only when CLKDIV_DYNAMIC_EN is defined.
interface pixel_clock_gen_if
  import clkdiv_pkg::*;
#(
  parameter int DIV_W = DIV_W_DEF
) ();

  logic             Pixel_clock;
  logic             Pixel_en;
  logic [DIV_W-1:0] Div_active;
`ifdef CLKDIV_DYNAMIC_EN
  logic [DIV_W-1:0] Div_sel;
  logic             Div_load;
  logic             Div_pending;
  logic             Div_err;

  modport master (
    output Pixel_clock,
    output Pixel_en,
    output Div_active,
    input  Div_sel,
    input  Div_load,
    output Div_pending,
    output Div_err
  );

  modport slave (
    input  Pixel_clock,
    input  Pixel_en,
    input  Div_active,
    output Div_sel,
    output Div_load,
    input  Div_pending,
    input  Div_err
  );
`else
  modport master (
    output Pixel_clock,
    output Pixel_en,
    output Div_active
  );

  modport slave (
    input  Pixel_clock,
    input  Pixel_en,
    input  Div_active
  );
`endif

endinterface

// File: rtl/clkdiv_ratio_reg.sv
// Run-time divide ratio register: pending slot, error check, apply at wrap.
// Built only when CLKDIV_DYNAMIC_EN is defined.
`ifdef CLKDIV_DYNAMIC_EN
module clkdiv_ratio_reg
  import clkdiv_pkg::*;
#(
  parameter int DIV_W       = DIV_W_DEF,
  parameter int DIV_DEFAULT = 2
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             wrap_i,
  input  logic [DIV_W-1:0] sel_i,
  input  logic             load_i,
  output logic [DIV_W-1:0] active_o,
  output logic             pending_o,
  output logic             err_o
);

  ratio_st_e        st_q, st_d;
  logic [DIV_W-1:0] pend_q, pend_d;
  logic [DIV_W-1:0] act_q, act_d;
  logic             err_q, err_d;
  logic             ok_w;

  assign ok_w = load_i && (sel_i >= DIV_W'(MIN_DIV));

  always_comb begin
    st_d   = st_q;
    pend_d = pend_q;
    act_d  = act_q;
    err_d  = load_i && !ok_w;
    if (wrap_i) begin
      // a load landing on the wrap itself beats the pending value
      st_d = R_IDLE;
      if (ok_w) begin
        act_d = sel_i;
      end else if (st_q == R_PENDING) begin
        act_d = pend_q;
      end
    end else if (ok_w) begin
      st_d   = R_PENDING;
      pend_d = sel_i;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      st_q   <= R_IDLE;
      pend_q <= DIV_W'(DIV_DEFAULT);
      act_q  <= DIV_W'(DIV_DEFAULT);
      err_q  <= 1'b0;
    end else begin
      st_q   <= st_d;
      pend_q <= pend_d;
      act_q  <= act_d;
      err_q  <= err_d;
    end
  end

  assign active_o  = act_q;
  assign pending_o = (st_q == R_PENDING);
  assign err_o     = err_q;

endmodule
`endif

// File: rtl/pixel_clock_gen.sv
// Divide-by-N pixel clock and one-cycle pixel enable from Sys_clock.
// CLKDIV_DYNAMIC_EN adds run-time ratio loading via clkdiv_ratio_reg.
module pixel_clock_gen
  import clkdiv_pkg::*;
#(
  parameter int DIV_W       = DIV_W_DEF,
  parameter int DIV_DEFAULT = 2
) (
  input  logic              Sys_clock,
  input  logic              Reset,
  pixel_clock_gen_if.master bus
);

  logic [DIV_W-1:0] cnt_q, cnt_d;
  logic [DIV_W-1:0] div_act;
  logic [DIV_W-1:0] hi_w;
  logic             wrap;
  logic             pc_q, pc_d;
  logic             en_q, en_d;

  assign wrap = (cnt_q == div_act - DIV_W'(1));
  assign hi_w = DIV_W'(half_up(32'(div_act)));

  // a new ratio only ever takes effect at cnt_d == 0, where pc/en are 1
  always_comb begin
    cnt_d = wrap ? '0 : cnt_q + DIV_W'(1);
    pc_d  = (cnt_d < hi_w);
    en_d  = (cnt_d == '0);
  end

  always_ff @(posedge Sys_clock) begin
    if (Reset) begin
      cnt_q <= '0;
      pc_q  <= 1'b0;
      en_q  <= 1'b0;
    end else begin
      cnt_q <= cnt_d;
      pc_q  <= pc_d;
      en_q  <= en_d;
    end
  end

`ifdef CLKDIV_DYNAMIC_EN
  clkdiv_ratio_reg #(
    .DIV_W      (DIV_W),
    .DIV_DEFAULT(DIV_DEFAULT)
  ) u_ratio (
    .clk_i    (Sys_clock),
    .rst_i    (Reset),
    .wrap_i   (wrap),
    .sel_i    (bus.Div_sel),
    .load_i   (bus.Div_load),
    .active_o (div_act),
    .pending_o(bus.Div_pending),
    .err_o    (bus.Div_err)
  );
`else
  assign div_act = DIV_W'(DIV_DEFAULT);
`endif

  assign bus.Pixel_clock = pc_q;
  assign bus.Pixel_en    = en_q;
  assign bus.Div_active  = div_act;

endmodule
